// File: rtl/sprite_pkg.sv
// Shared types for the multi-sprite engine: directions, HID key codes,
// per-sprite working state and the frame-update FSM states.
package sprite_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  // Storage widths are generous so one struct serves any COORD_W up to 15
  // and ANIM_DIV up to 256; the engine does its arithmetic on a narrower slice.
  localparam int SPR_POS_W = 16;
  localparam int SPR_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_COMMIT = 2'd2
  } fsm_state_t;

  typedef struct packed {
    logic signed [SPR_POS_W-1:0] x;
    logic signed [SPR_POS_W-1:0] y;
    logic signed [SPR_POS_W-1:0] vx;
    logic signed [SPR_POS_W-1:0] vy;
    dir_t                        dir;
    logic [1:0]                  anim;
    logic [SPR_CNT_W-1:0]        anim_cnt;
  } sprite_state_t;

  // Map one HID keycode byte to {valid, direction}; valid is 0 for any
  // byte that is not one of the four steering keys.
  function automatic logic [2:0] decodeKey(input logic [7:0] code);
    case (code)
      KEY_W:   decodeKey = {1'b1, DIR_UP};
      KEY_S:   decodeKey = {1'b1, DIR_DOWN};
      KEY_A:   decodeKey = {1'b1, DIR_LEFT};
      KEY_D:   decodeKey = {1'b1, DIR_RIGHT};
      default: decodeKey = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/vsync_edge_sync.sv
// Brings the asynchronous active-low VGA vertical sync into the Clk domain
// and produces a one-cycle pulse on each synchronised falling edge.
module vsync_edge_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic vs_n_i,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Two-flop synchroniser plus a history flop; idle level of vs_n is high.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= vs_n_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/multi_sprite_engine.sv
// Per-frame position/direction/animation update for NUM_SPRITES sprites.
// One sprite is keyboard steered, the rest bounce; results are swept into
// shadow state one sprite per cycle and committed to the outputs at once.
module multi_sprite_engine
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int COORD_W     = 11,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int SPRITE_W    = 32,
  parameter int SPRITE_H    = 32,
  parameter int STEP        = 2,
  parameter int ANIM_DIV    = 8
) (
  input  logic                             Clk,
  input  logic                             Reset_n,
  input  logic                             vs_n,
  input  logic [15:0]                      keycode,
  input  logic [$clog2(NUM_SPRITES)-1:0]   ctrl_sel,
  output logic [NUM_SPRITES*COORD_W-1:0]   sprite_x,
  output logic [NUM_SPRITES*COORD_W-1:0]   sprite_y,
  output logic [NUM_SPRITES*4-1:0]         motion,
  output logic                             frame_tick,
  output logic                             update_done,
  output logic [15:0]                      frame_count
);

  localparam int IW  = $clog2(NUM_SPRITES);
  localparam int PW  = COORD_W + 1;
  localparam int ACW = $clog2(ANIM_DIV);

  localparam logic signed [PW-1:0] ZERO_S  = '0;
  localparam logic signed [PW-1:0] STEP_S  = PW'(STEP);
  localparam logic signed [PW-1:0] X_MAX_S = PW'(SCREEN_W - SPRITE_W);
  localparam logic signed [PW-1:0] Y_MAX_S = PW'(SCREEN_H - SPRITE_H);
  localparam logic signed [SPR_POS_W-1:0] RESET_Y = SPR_POS_W'(SCREEN_H/2 - SPRITE_H/2);

  function automatic logic signed [SPR_POS_W-1:0] resetX(input int i);
    return SPR_POS_W'(i * (SCREEN_W / NUM_SPRITES));
  endfunction

  function automatic sprite_state_t resetSprite(input int i);
    sprite_state_t s;
    s.x        = resetX(i);
    s.y        = RESET_Y;
    s.vx       = SPR_POS_W'(STEP);
    s.vy       = SPR_POS_W'(STEP);
    s.dir      = DIR_RIGHT;
    s.anim     = '0;
    s.anim_cnt = '0;
    return s;
  endfunction

  logic                         fall;
  logic                         frame_tick_q;
  logic [15:0]                  frame_count_q;
  fsm_state_t                   state_q;
  logic [IW-1:0]                idx_q;
  logic [IW-1:0]                sel_q;
  logic [15:0]                  key_q;
  logic                         update_done_q;
  sprite_state_t                shadow_q [NUM_SPRITES];
  logic [NUM_SPRITES*COORD_W-1:0] sprite_x_q;
  logic [NUM_SPRITES*COORD_W-1:0] sprite_y_q;
  logic [NUM_SPRITES*4-1:0]     motion_q;

  sprite_state_t                cur;
  sprite_state_t                sprite_d;
  logic signed [PW-1:0]         cx, cy, nx, ny, vx, vy;
  logic [2:0]                   priKey, secKey, keySel;
  logic                         moving, idle;

  vsync_edge_sync u_vsync (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .vs_n_i  (vs_n),
    .fall_o  (fall)
  );

  // Frame strobe and free-running frame counter; every detected edge counts,
  // even one the FSM is too busy to act on.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_tick_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_tick_q <= fall;
      if (fall) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  // Next state of the sprite currently selected by the sweep index.
  always_comb begin
    cur      = shadow_q[idx_q];
    sprite_d = cur;
    cx       = cur.x[PW-1:0];
    cy       = cur.y[PW-1:0];
    vx       = cur.vx[PW-1:0];
    vy       = cur.vy[PW-1:0];
    nx       = cx;
    ny       = cy;
    moving   = 1'b0;
    idle     = 1'b0;
    priKey   = decodeKey(key_q[7:0]);
    secKey   = decodeKey(key_q[15:8]);
    keySel   = priKey[2] ? priKey : secKey;
    if (idx_q == sel_q) begin
      if (keySel[2]) begin
        sprite_d.dir = dir_t'(keySel[1:0]);
        case (dir_t'(keySel[1:0]))
          DIR_UP:   ny = cy - STEP_S;
          DIR_DOWN: ny = cy + STEP_S;
          DIR_LEFT: nx = cx - STEP_S;
          default:  nx = cx + STEP_S;
        endcase
        if (nx < ZERO_S) nx = ZERO_S;
        else if (nx > X_MAX_S) nx = X_MAX_S;
        if (ny < ZERO_S) ny = ZERO_S;
        else if (ny > Y_MAX_S) ny = Y_MAX_S;
        moving = (nx != cx) || (ny != cy);
      end else begin
        idle = 1'b1;
      end
    end else begin
      moving = 1'b1;
      nx = cx + vx;
      ny = cy + vy;
      if (nx <= ZERO_S) begin
        nx          = ZERO_S;
        sprite_d.vx = -cur.vx;
      end else if (nx >= X_MAX_S) begin
        nx          = X_MAX_S;
        sprite_d.vx = -cur.vx;
      end
      if (ny <= ZERO_S) begin
        ny          = ZERO_S;
        sprite_d.vy = -cur.vy;
      end else if (ny >= Y_MAX_S) begin
        ny          = Y_MAX_S;
        sprite_d.vy = -cur.vy;
      end
      sprite_d.dir = sprite_d.vx[SPR_POS_W-1] ? DIR_LEFT : DIR_RIGHT;
    end
    sprite_d.x = SPR_POS_W'(nx);
    sprite_d.y = SPR_POS_W'(ny);
    if (moving) begin
      if (cur.anim_cnt[ACW-1:0] == ACW'(ANIM_DIV - 1)) begin
        sprite_d.anim_cnt = '0;
        sprite_d.anim     = cur.anim + 2'd1;
      end else begin
        sprite_d.anim_cnt = cur.anim_cnt + 1'b1;
      end
    end else if (idle) begin
      sprite_d.anim     = '0;
      sprite_d.anim_cnt = '0;
    end
  end

  // Frame-update FSM: latch inputs on the frame edge, sweep every sprite into
  // shadow state, then publish the whole set in a single commit cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      sel_q         <= '0;
      key_q         <= '0;
      update_done_q <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_q[i]                      <= resetSprite(i);
        sprite_x_q[i*COORD_W +: COORD_W] <= COORD_W'(resetX(i));
        sprite_y_q[i*COORD_W +: COORD_W] <= COORD_W'(RESET_Y);
        motion_q[i*4 +: 4]               <= {DIR_RIGHT, 2'b00};
      end
    end else begin
      update_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fall) begin
            sel_q   <= ctrl_sel;
            key_q   <= keycode;
            idx_q   <= '0;
            state_q <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          shadow_q[idx_q] <= sprite_d;
          if (idx_q == IW'(NUM_SPRITES - 1)) state_q <= ST_COMMIT;
          else idx_q <= idx_q + 1'b1;
        end
        ST_COMMIT: begin
          for (int i = 0; i < NUM_SPRITES; i++) begin
            sprite_x_q[i*COORD_W +: COORD_W] <= shadow_q[i].x[COORD_W-1:0];
            sprite_y_q[i*COORD_W +: COORD_W] <= shadow_q[i].y[COORD_W-1:0];
            motion_q[i*4 +: 4]               <= {shadow_q[i].dir, shadow_q[i].anim};
          end
          update_done_q <= 1'b1;
          state_q       <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sprite_x    = sprite_x_q;
  assign sprite_y    = sprite_y_q;
  assign motion      = motion_q;
  assign frame_tick  = frame_tick_q;
  assign update_done = update_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_multi_sprite_engine.sv
// Self-checking bench for multi_sprite_engine with default parameters.
module tb_multi_sprite_engine;

  logic        Clk;
  logic        Reset_n;
  logic        vs_n;
  logic [15:0] keycode;
  logic [1:0]  ctrl_sel;
  logic [43:0] sprite_x;
  logic [43:0] sprite_y;
  logic [15:0] motion;
  logic        frame_tick;
  logic        update_done;
  logic [15:0] frame_count;

  localparam logic [43:0] RST_X = {11'd480, 11'd320, 11'd160, 11'd0};
  localparam logic [43:0] RST_Y = {4{11'd224}};
  localparam logic [15:0] RST_M = 16'hCCCC;

  typedef struct packed {
    logic [43:0] xs;
    logic [43:0] ys;
    logic [15:0] mo;
  } exp_t;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] key;
    int          frames;
    int          expX;
    int          expY;
    int          expDir;
    int          expAnim;
  } vec_t;

  int   vecCount  = 0;
  int   missCount = 0;
  int   expFrames = 0;
  exp_t expQ[$];
  exp_t expNow;
  vec_t vecs[8];

  // Reference model of every sprite, kept as plain integers.
  int mx[4], my[4], mvx[4], mvy[4], mdir[4], manim[4], mcnt[4];

  multi_sprite_engine dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .vs_n        (vs_n),
    .keycode     (keycode),
    .ctrl_sel    (ctrl_sel),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .motion      (motion),
    .frame_tick  (frame_tick),
    .update_done (update_done),
    .frame_count (frame_count)
  );

  // 50 MHz clock.
  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  // Hard stop if anything ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected to have finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    vecCount++;
    if (act !== expv) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic int keyToDir(input int code);
    if (code == 'h1A) return 0;
    if (code == 'h16) return 1;
    if (code == 'h04) return 2;
    if (code == 'h07) return 3;
    return -1;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      mx[i] = i * 160; my[i] = 224; mvx[i] = 2; mvy[i] = 2;
      mdir[i] = 3; manim[i] = 0; mcnt[i] = 0;
    end
  endtask

  // One frame of the reference behaviour.
  task automatic modelFrame(input int sel, input int key);
    int d;
    d = keyToDir(key & 255);
    if (d < 0) d = keyToDir((key >> 8) & 255);
    for (int i = 0; i < 4; i++) begin
      int ox, oy;
      bit idle, moved;
      ox = mx[i]; oy = my[i]; idle = 0;
      if (i == sel) begin
        if (d < 0) idle = 1;
        else begin
          mdir[i] = d;
          if (d == 0) my[i] = (my[i] - 2 < 0) ? 0 : my[i] - 2;
          if (d == 1) my[i] = (my[i] + 2 > 448) ? 448 : my[i] + 2;
          if (d == 2) mx[i] = (mx[i] - 2 < 0) ? 0 : mx[i] - 2;
          if (d == 3) mx[i] = (mx[i] + 2 > 608) ? 608 : mx[i] + 2;
        end
      end else begin
        mx[i] += mvx[i];
        my[i] += mvy[i];
        if (mx[i] <= 0) begin mx[i] = 0; mvx[i] = -mvx[i]; end
        else if (mx[i] >= 608) begin mx[i] = 608; mvx[i] = -mvx[i]; end
        if (my[i] <= 0) begin my[i] = 0; mvy[i] = -mvy[i]; end
        else if (my[i] >= 448) begin my[i] = 448; mvy[i] = -mvy[i]; end
        mdir[i] = (mvx[i] < 0) ? 2 : 3;
      end
      moved = (mx[i] != ox) || (my[i] != oy);
      if (moved) begin
        mcnt[i]++;
        if (mcnt[i] == 8) begin mcnt[i] = 0; manim[i] = (manim[i] + 1) % 4; end
      end else if (idle) begin
        manim[i] = 0; mcnt[i] = 0;
      end
    end
  endtask

  task automatic pushExpected();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.xs[i*11 +: 11] = 11'(mx[i]);
      e.ys[i*11 +: 11] = 11'(my[i]);
      e.mo[i*4 +: 4]   = {2'(mdir[i]), 2'(manim[i])};
    end
    expQ.push_back(e);
  endtask

  // Scoreboard: every committed update is matched against the oldest prediction.
  always @(negedge Clk) begin
    if (update_done) begin
      if (expQ.size() == 0) begin
        vecCount++;
        missCount++;
        $display("[TB] FAIL unexpected_update: got update_done=1, expected 0");
      end else begin
        expNow = expQ.pop_front();
        checkOutput("sprite_x", 64'(sprite_x), 64'(expNow.xs));
        checkOutput("sprite_y", 64'(sprite_y), 64'(expNow.ys));
        checkOutput("motion", 64'(motion), 64'(expNow.mo));
      end
    end
  end

  // One vsync falling edge with the given controls; checks strobe latencies
  // and the frame counter, while the scoreboard checks the committed data.
  task automatic applyStimulus(input logic [1:0] sel, input logic [15:0] key);
    int tickAt, doneAt;
    ctrl_sel = sel;
    keycode  = key;
    modelFrame(int'(sel), int'(key));
    pushExpected();
    expFrames++;
    vs_n   = 1'b0;
    tickAt = -1;
    doneAt = -1;
    for (int k = 1; k <= 30 && doneAt < 0; k++) begin
      @(negedge Clk);
      if (frame_tick && tickAt < 0) tickAt = k;
      if (update_done && doneAt < 0) doneAt = k;
    end
    checkOutput("tick_latency", 64'(tickAt), 64'(3));
    checkOutput("done_latency", 64'(doneAt), 64'(8));
    checkOutput("frame_count", 64'(frame_count), 64'(expFrames));
    vs_n = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    int tickCnt, doneCnt, s;

    vecs[0] = '{2'd0, 16'h0007, 1, 2,   224, 3, -1};
    vecs[1] = '{2'd0, 16'h0004, 6, 0,   224, 2, -1};
    vecs[2] = '{2'd0, 16'h071A, 1, 0,   222, 0, -1};
    vecs[3] = '{2'd0, 16'h1A00, 1, 0,   220, 0, -1};
    vecs[4] = '{2'd0, 16'h2C00, 1, 0,   220, 0,  0};
    vecs[5] = '{2'd0, 16'h0016, 1, 0,   222, 1, -1};
    vecs[6] = '{2'd1, 16'h0007, 1, 184, 246, 3, -1};
    vecs[7] = '{2'd1, 16'h0016, 2, 184, 250, 1, -1};

    Reset_n  = 1'b0;
    vs_n     = 1'b1;
    keycode  = '0;
    ctrl_sel = '0;
    modelReset();
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Reset state.
    checkOutput("reset_x", 64'(sprite_x), 64'(RST_X));
    checkOutput("reset_y", 64'(sprite_y), 64'(RST_Y));
    checkOutput("reset_motion", 64'(motion), 64'(RST_M));
    checkOutput("reset_frame_count", 64'(frame_count), 64'(0));
    checkOutput("reset_tick", 64'(frame_tick), 64'(0));
    checkOutput("reset_done", 64'(update_done), 64'(0));

    // Table of keyboard scenarios; hand values for the controlled sprite.
    for (int v = 0; v < 8; v++) begin
      for (int f = 0; f < vecs[v].frames; f++) applyStimulus(vecs[v].sel, vecs[v].key);
      s = int'(vecs[v].sel);
      checkOutput($sformatf("vec%0d_x", v), 64'(sprite_x[s*11 +: 11]), 64'(vecs[v].expX));
      checkOutput($sformatf("vec%0d_y", v), 64'(sprite_y[s*11 +: 11]), 64'(vecs[v].expY));
      checkOutput($sformatf("vec%0d_dir", v), 64'(motion[s*4+2 +: 2]), 64'(vecs[v].expDir));
      if (vecs[v].expAnim >= 0)
        checkOutput($sformatf("vec%0d_anim", v), 64'(motion[s*4 +: 2]), 64'(vecs[v].expAnim));
    end

    // Second vsync edge lands while the FSM is committing: counted, not applied.
    ctrl_sel = 2'd0;
    keycode  = 16'h0007;
    modelFrame(0, 'h0007);
    pushExpected();
    tickCnt = 0;
    doneCnt = 0;
    vs_n    = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge Clk);
      if (k == 1) vs_n = 1'b1;
      if (k == 5) vs_n = 1'b0;
      if (k == 6) vs_n = 1'b1;
      if (frame_tick) tickCnt++;
      if (update_done) doneCnt++;
      if (k == 8) checkOutput("commit_overlap_tick", 64'(frame_tick), 64'(1));
    end
    expFrames += 2;
    checkOutput("drop_tick_count", 64'(tickCnt), 64'(2));
    checkOutput("drop_done_count", 64'(doneCnt), 64'(1));
    checkOutput("drop_frame_count", 64'(frame_count), 64'(expFrames));

    // Reset asserted in the middle of a sweep.
    ctrl_sel = 2'd0;
    keycode  = 16'h0016;
    vs_n     = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clk);
      if (k == 1) vs_n = 1'b1;
    end
    Reset_n = 1'b0;
    #1;
    checkOutput("abort_x", 64'(sprite_x), 64'(RST_X));
    checkOutput("abort_y", 64'(sprite_y), 64'(RST_Y));
    checkOutput("abort_motion", 64'(motion), 64'(RST_M));
    checkOutput("abort_frame_count", 64'(frame_count), 64'(0));
    @(negedge Clk);
    Reset_n = 1'b1;
    modelReset();
    expFrames = 0;
    doneCnt   = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (update_done) doneCnt++;
    end
    checkOutput("abort_no_done", 64'(doneCnt), 64'(0));
    checkOutput("abort_x_held", 64'(sprite_x), 64'(RST_X));

    // Autonomous sprite 3 runs into the right edge and turns back.
    for (int f = 0; f < 64; f++) applyStimulus(2'd0, 16'h0000);
    checkOutput("bounce_x_at_edge", 64'(sprite_x[33 +: 11]), 64'(608));
    applyStimulus(2'd0, 16'h0000);
    checkOutput("bounce_x_after", 64'(sprite_x[33 +: 11]), 64'(606));
    checkOutput("bounce_dir_after", 64'(motion[15:14]), 64'(2));
    checkOutput("idle_sprite0_x", 64'(sprite_x[10:0]), 64'(0));

    repeat (4) @(negedge Clk);
    checkOutput("queue_drained", 64'(expQ.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/multi_sprite_engine.md
Name: multi_sprite_engine

Overview:
- Parametrised successor to the single-sprite controller/state pair: holds position, direction and animation frame for NUM_SPRITES sprites in the 50 MHz Clk domain.
- Sprite at index ctrl_sel is driven by the USB keycode. All others bounce autonomously.
- Updates once per frame, triggered by the VGA vertical sync. The sync is synchronised into Clk, not used as a clock.
- Results are double-buffered, so color_mapper always sees a coherent position/motion set.

Parameters:
NUM_SPRITES, 4, number of sprites (2..16)
COORD_W, 11, coordinate width, matching DrawX/DrawY
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
SPRITE_W, 32, sprite width in pixels
SPRITE_H, 32, sprite height in pixels
STEP, 2, pixels moved per frame
ANIM_DIV, 8, moving frames per animation-frame advance

Ports:
Clk  in  1  system clock, 50 MHz
Reset_n  in  1  asynchronous active-low reset
vs_n  in  1  VGA vertical sync, active low, asynchronous to Clk
keycode  in  16  two HID keycodes: [7:0] primary, [15:8] secondary
ctrl_sel  in  $clog2(NUM_SPRITES)  index of the keyboard-controlled sprite
sprite_x  out  NUM_SPRITES*COORD_W  packed x coordinates, sprite i at [i*COORD_W +: COORD_W]
sprite_y  out  NUM_SPRITES*COORD_W  packed y coordinates, same packing
motion  out  NUM_SPRITES*4  per sprite: [3:2] dir (UP=0, DOWN=1, LEFT=2, RIGHT=3), [1:0] anim frame
frame_tick  out  1  one-cycle pulse per detected frame
update_done  out  1  one-cycle pulse when the committed outputs change
frame_count  out  16  frames since reset, wraps at 0xFFFF->0

Behaviour:
- Reset is asynchronous, active-low.
- Reset values for sprite i:
  - x = i*(SCREEN_W/NUM_SPRITES); y = SCREEN_H/2 - SPRITE_H/2 (224)
  - dir = RIGHT, anim = 0
  - autonomous velocity (+STEP, +STEP)
- Reset values for strobes/counters: frame_tick = 0, update_done = 0, frame_count = 0, FSM = IDLE.
- Assertion mid-sweep aborts the sweep; no partial commit.
- Frame detection:
  - vs_n goes through a 2-flop synchroniser, then falling-edge detect.
  - frame_tick asserts 3 Clk cycles after the vs_n falling edge; frame_count increments on the same cycle.
- FSM states: IDLE -> SWEEP -> COMMIT -> IDLE.
  - IDLE: on frame_tick, latch ctrl_sel and keycode, set idx = 0, go to SWEEP.
  - SWEEP: process sprite idx into the shadow registers, one sprite per cycle; after idx = NUM_SPRITES-1, go to COMMIT.
  - COMMIT: copy all shadow registers to the outputs in one cycle, pulse update_done, return to IDLE.
  - Outputs therefore change exactly NUM_SPRITES+1 cycles after frame_tick.
  - A frame_tick arriving outside IDLE is dropped for the update but still counted in frame_count.
- Key decode (HID codes):
  - W = 0x1A up, S = 0x16 down, A = 0x04 left, D = 0x07 right.
  - Primary byte wins. The secondary byte is used only if the primary byte is not one of these four codes.
  - No direction key: sprite idle.
- Controlled sprite:
  - Moves STEP in the key direction.
  - Clamps to x in [0, SCREEN_W-SPRITE_W] and y in [0, SCREEN_H-SPRITE_H]; no wrap.
  - dir updates to the key direction; when idle, dir holds and anim resets to 0.
- Autonomous sprites:
  - pos += velocity each frame.
  - If the next position would cross a bound, clamp to the bound and negate that velocity component.
  - dir = RIGHT/LEFT from the x velocity sign.
- Animation:
  - Each sprite has a $clog2(ANIM_DIV)-bit frame counter that counts only while the sprite moves.
  - On wrap, anim = anim+1 mod 4.
- Arithmetic:
  - Coordinates are signed COORD_W+1 bits internally, so underflow below 0 is detectable before the clamp.
  - Outputs are unsigned COORD_W.
- ctrl_sel change: takes effect at the next frame_tick. A sprite leaving keyboard control resumes its stored velocity.

Decomposition:
- Package sprite_pkg:
  - dir_t enum and HID key constants (KEY_W/A/S/D)
  - sprite_state_t struct {x, y, vx, vy, dir, anim, anim_cnt}
  - fsm state enum
- Sub-module vsync_edge_sync: 2-flop synchroniser plus falling-edge pulse, with its own Clk/Reset_n.

Test Plan:
- Reset then release: sprite_x = {0,160,320,480}, all y = 224, motion = 4'b1100 for every sprite, frame_count = 0.
- ctrl_sel = 0, keycode = 0x0007, one vs_n falling edge:
  - frame_tick 3 cycles after the edge; update_done 5 cycles after frame_tick
  - sprite0 x = 2, dir RIGHT; sprites 1..3 at x+2, y = 226.
- ctrl_sel = 0 at x = 0, keycode = 0x0004 for 5 frames: x stays 0 (clamp), dir = LEFT.
- Autonomous sprite 3 from x = 480: after 64 frames it reaches x = 608 and clamps; on the next frame the x velocity negates, giving x = 606, dir LEFT.
- keycode = 0x071A: primary W wins, y -= 2. keycode = 0x1A00: secondary W, same response. keycode = 0x2C00: idle, anim = 0.
- Reset_n low mid-SWEEP, plus a vs_n edge during COMMIT:
  - outputs return to reset values immediately; update_done absent
  - the dropped frame is still counted in frame_count.
